// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester byte handshake plus the UART transmitter start/data/done link
interface uart_tx_arbiter_if #(parameter int NUM_REQ = 4);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [8*NUM_REQ-1:0] req_data;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_done;
    modport master (input req_valid, req_data, tx_done, output req_ready, tx_start, tx_data);
    modport slave (output req_valid, req_data, tx_done, input req_ready, tx_start, tx_data);
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one UART TX with watchdog; UART_ARB_FIXED_PRI_EN selects fixed lowest-index priority
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int GAP_CYCLES = 0,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_tx_arbiter_if.master     bus,
    output logic                  busy,
    output logic [IW-1:0]         grant_id,
    output logic                  err_timeout,
    output logic [15:0]           frame_count
);
    localparam int CMAX = TIMEOUT_CYCLES > GAP_CYCLES ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int CW = $clog2(CMAX + 1);
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    sync;
    logic          done_d;
    logic          done_s;
    logic          done_rise;
    logic [IW-1:0] base;
    logic [IW-1:0] idx;
    logic [IW-1:0] sel;
    logic          found;
    assign done_s = sync[1];
    assign done_rise = done_s & ~done_d;
`ifdef UART_ARB_FIXED_PRI_EN
    assign base = '0;
`else
    logic [IW-1:0] ptr;
    logic [IW-1:0] nxt;
    assign base = ptr;
    assign nxt = grant_id == IW'(NUM_REQ - 1) ? '0 : grant_id + 1'b1;
`endif
    // first valid requester at or after base, wrapping modulo NUM_REQ
    always_comb begin
        sel = '0;
        idx = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IW'((int'(base) + k) % NUM_REQ);
            if (!found && bus.req_valid[idx]) begin
                sel = idx;
                found = 1'b1;
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            sync <= '0;
            done_d <= 1'b0;
            bus.req_ready <= '0;
            bus.tx_start <= 1'b0;
            bus.tx_data <= '0;
            busy <= 1'b0;
            grant_id <= '0;
            err_timeout <= 1'b0;
            frame_count <= '0;
`ifndef UART_ARB_FIXED_PRI_EN
            ptr <= '0;
`endif
        end else begin
            sync <= {sync[0], bus.tx_done};
            done_d <= done_s;
            bus.req_ready <= '0;
            err_timeout <= 1'b0;
            case (state)
                IDLE: if (found) begin
                    bus.req_ready <= NUM_REQ'(1) << sel;
                    bus.tx_data <= bus.req_data[{sel, 3'b000} +: 8];
                    bus.tx_start <= 1'b1;
                    grant_id <= sel;
                    busy <= 1'b1;
                    cnt <= '0;
                    state <= SEND;
                end
                SEND: if (done_rise) begin
                    bus.tx_start <= 1'b0;
                    frame_count <= frame_count + 1'b1;
                    cnt <= '0;
                    state <= GAP;
                end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    bus.tx_start <= 1'b0;
                    err_timeout <= 1'b1;
                    cnt <= '0;
                    state <= GAP;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                // hold off until the transmitter drops done so no duplicate frame is launched
                GAP: if (!done_s) begin
                    if (cnt == CW'(GAP_CYCLES)) begin
`ifndef UART_ARB_FIXED_PRI_EN
                        ptr <= nxt;
`endif
                        busy <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench; stimulus queues expected grants, a monitor checks each tx_start launch
module tb_uart_tx_arbiter;
    localparam int N = 4;
    typedef struct {
        logic [7:0] d;
        logic [1:0] g;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy;
    logic [1:0]  grant_id;
    logic        err_timeout;
    logic [15:0] frame_count;
    int          vectors = 0;
    int          miscompares = 0;
    int          errs = 0;
    bit          hang = 1'b0;
    logic        prev_start = 1'b0;
    exp_t        q[$];
    exp_t        e;
    uart_tx_arbiter_if #(.NUM_REQ(N)) bus();
    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(64), .GAP_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy(busy), .grant_id(grant_id),
        .err_timeout(err_timeout), .frame_count(frame_count)
    );
    always #5 clk = ~clk;
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic push(logic [7:0] d, logic [1:0] g);
        exp_t x;
        x.d = d;
        x.g = g;
        q.push_back(x);
    endtask
    task automatic wait_ready();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.req_ready == 0 && n < 1000);
        chk("ready_seen", 32'(bus.req_ready != 0), 1);
    endtask
    task automatic wait_idle(string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 1000);
        chk(name, 32'(busy), 0);
    endtask
    task automatic chk_reset(string tag);
        chk({tag, "_ready"}, 32'(bus.req_ready), 0);
        chk({tag, "_start"}, 32'(bus.tx_start), 0);
        chk({tag, "_data"}, 32'(bus.tx_data), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_grant"}, 32'(grant_id), 0);
        chk({tag, "_err"}, 32'(err_timeout), 0);
        chk({tag, "_frames"}, 32'(frame_count), 0);
    endtask
    // transmitter model: done rises 20 cycles after a launch and stays high 4 cycles
    initial begin
        bus.tx_done = 1'b0;
        forever begin
            @(posedge bus.tx_start);
            if (!hang) begin
                repeat (20) @(negedge clk);
                bus.tx_done = 1'b1;
                repeat (4) @(negedge clk);
                bus.tx_done = 1'b0;
            end
        end
    end
    always @(negedge clk) begin
        if (err_timeout) errs++;
        if (bus.tx_start && !prev_start) begin
            if (q.size() == 0) begin
                chk("unexpected_launch", 32'(grant_id), 32'hFFFF);
            end else begin
                e = q.pop_front();
                chk("launch_data", 32'(bus.tx_data), 32'(e.d));
                chk("launch_grant", 32'(grant_id), 32'(e.g));
                chk("launch_ready", 32'(bus.req_ready), 32'(4'b0001 << e.g));
            end
        end
        prev_start <= bus.tx_start;
    end
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
    initial begin
        bus.req_valid = '0;
        bus.req_data = '0;
        repeat (3) @(negedge clk);
        chk_reset("rst");
        rst = 1'b0;
        bus.req_data = 32'h0000_00A5;
        push(8'hA5, 2'd0);
        bus.req_valid = 4'b0001;
        wait_ready();
        chk("a_busy", 32'(busy), 1);
        bus.req_valid = '0;
        wait_idle("a_idle");
        chk("a_frames", 32'(frame_count), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.req_data = 32'h4332_2110;
`ifdef UART_ARB_FIXED_PRI_EN
        repeat (5) push(8'h10, 2'd0);
`else
        push(8'h10, 2'd0);
        push(8'h21, 2'd1);
        push(8'h32, 2'd2);
        push(8'h43, 2'd3);
        push(8'h10, 2'd0);
`endif
        bus.req_valid = 4'b1111;
        repeat (5) wait_ready();
        bus.req_valid = '0;
        wait_idle("rr_idle");
        chk("rr_frames", 32'(frame_count), 5);
        hang = 1'b1;
        push(8'h21, 2'd1);
`ifdef UART_ARB_FIXED_PRI_EN
        push(8'h21, 2'd1);
`else
        push(8'h32, 2'd2);
`endif
        bus.req_valid = 4'b0110;
        wait_ready();
        begin
            int n = 0;
            while (bus.tx_start && n < 200) begin
                n++;
                @(negedge clk);
            end
            chk("to_start_cycles", 32'(n), 64);
        end
        chk("to_frames_held", 32'(frame_count), 5);
        hang = 1'b0;
        wait_ready();
        bus.req_valid = '0;
        wait_idle("to_idle");
        chk("to_err_pulses", 32'(errs), 1);
        chk("to_frames_after", 32'(frame_count), 6);
        hang = 1'b1;
        push(8'h43, 2'd3);
        bus.req_valid = 4'b1000;
        wait_ready();
        bus.req_valid = 4'b1001;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset("mid");
        push(8'h10, 2'd0);
        repeat (3) @(negedge clk);
        hang = 1'b0;
        rst = 1'b0;
        wait_ready();
        chk("mid_grant", 32'(grant_id), 0);
        bus.req_valid = '0;
        wait_idle("mid_idle");
        chk("mid_frames", 32'(frame_count), 1);
        force dut.frame_count = 16'hFFFF;
        @(negedge clk);
        release dut.frame_count;
        @(negedge clk);
        chk("wrap_pre", 32'(frame_count), 32'hFFFF);
        bus.req_data = 32'h0000_005A;
        push(8'h5A, 2'd0);
        bus.req_valid = 4'b0001;
        wait_ready();
        bus.req_valid = '0;
        wait_idle("wrap_idle");
        chk("wrap_frames", 32'(frame_count), 0);
        chk("queue_empty", 32'(q.size()), 0);
        chk("err_total", 32'(errs), 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between NUM_REQ byte-producing requesters using round-robin arbitration.
- Accepts a byte from the granted requester and drives the transmitter's start/data inputs. Waits for the transmitter's done flag, then releases the link.
- Sits between the on-chip message sources (status, debug, command-response) and the single UART TX datapath.
- Includes a watchdog timeout, so a hung transmitter cannot stall all requesters.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 4096, clk cycles allowed in SEND before abort. Must exceed 12 × (clk_freq/baud).
- GAP_CYCLES, 0, extra idle clk cycles inserted after each frame before the next grant.

Ports:
- clk  in  1  system clock; same clock that feeds the transmitter's baud generator.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester byte-valid.
- req_data  in  8*NUM_REQ  per-requester byte; requester i owns bits [8i+7:8i].
- req_ready  out  NUM_REQ  one-cycle accept pulse, one-hot.
- tx_start  out  1  to transmitter data_update.
- tx_data  out  8  to transmitter din_tx.
- tx_done  in  1  from transmitter done_tx; asynchronous to this block.
- busy  out  1  high in any state except IDLE.
- grant_id  out  clog2(NUM_REQ)  index of the current or last granted requester.
- err_timeout  out  1  one-cycle pulse when the watchdog aborts a frame.
- frame_count  out  16  count of completed frames; wraps 0xFFFF→0; timeouts not counted.

Behaviour:
- Reset values: req_ready=0, tx_start=0, tx_data=0x00, busy=0, grant_id=0, err_timeout=0, frame_count=0.
  - Reset also clears: state=IDLE, round-robin pointer=0, sync flops=0.
- tx_done input: passes through a 2-flop synchronizer, then a rising-edge detector (done_rise) and a level (done_s).
- State IDLE:
  - If any req_valid is high, select the first set bit searching from pointer upward, wrapping modulo NUM_REQ.
  - On selection: pulse req_ready[sel] for one cycle, latch req_data[sel] into tx_data, set grant_id=sel, clear watchdog, go to SEND.
  - Requester handshake: a byte is consumed only in a cycle where req_valid[i] and req_ready[i] are both high. A requester may drop req_valid at any time before acceptance.
- State SEND:
  - tx_start=1; tx_data is held stable.
  - The watchdog increments each cycle.
  - On done_rise: tx_start=0, frame_count+1, go to GAP.
  - Else, if watchdog reaches TIMEOUT_CYCLES-1: tx_start=0, pulse err_timeout, go to GAP.
  - If done_rise and the timeout fall in the same cycle, done wins: no error, frame is counted.
- State GAP:
  - tx_start=0.
  - Wait until done_s=0, then count GAP_CYCLES cycles; GAP_CYCLES=0 means zero extra cycles.
  - Then: pointer=grant_id+1 (wrapping NUM_REQ-1→0), go to IDLE.
  - Waiting for done_s to fall guarantees tx_start is low at the transmitter's next idle baud edge, so no duplicate frame is sent.
- Latency: req_valid high in IDLE gives req_ready on the next clk edge; tx_start rises in the same cycle req_ready pulses.
- Fairness: a requester with valid held high waits at most NUM_REQ-1 frames.
- Reset mid-frame: all outputs return to their reset values immediately. The latched byte is lost; the requester has already seen ready and does not resend.
- Constraint: clk_freq/baud ≥ 16, so tx_start drops well within half a baud period after done.

Optional Feature:
- Macro: UART_ARB_FIXED_PRI_EN.
- Defined: the round-robin pointer is ignored; IDLE always grants the lowest-index valid requester. The pointer register is removed.
- Undefined: round-robin arbitration as described above.

Test Plan:
- Reset, then req_valid=0001 with req_data[7:0]=0xA5:
  - req_ready=0001 for 1 cycle; tx_start=1, tx_data=0xA5.
  - After tx_done pulse: frame_count=1, busy returns to 0.
- req_valid=1111 held, bytes 0x10/0x21/0x32/0x43:
  - Transmitter receives 0x10, 0x21, 0x32, 0x43, 0x10 in order; grant_id cycles 0,1,2,3,0.
- Same stimulus with UART_ARB_FIXED_PRI_EN defined:
  - Every grant goes to requester 0; 0x10 is repeated.
- tx_done tied low, TIMEOUT_CYCLES=64:
  - tx_start high for exactly 64 cycles; err_timeout pulses once; frame_count stays 0; next requester is granted.
- rst asserted for 3 cycles mid-SEND:
  - All outputs at reset values; after release, a pending request is granted starting from requester 0.
- frame_count preloaded via 65536 frames, or forced to 0xFFFF:
  - One more completed frame gives frame_count=0x0000.
